// File: rtl/ones_count_engine_if.sv
// Word-in / count-out handshake bundle for the population-count engine.
// The master drives words and accepts results; the slave is the engine.
interface ones_count_engine_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_zero;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_zero
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_zero
  );
endinterface

// File: rtl/ones_count_engine.sv
// Multi-cycle popcount: CHUNK_W bits per clock, valid/ready on both sides,
// plus running counts of completed words and all-zero words.
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// COUNT | summing one chunk per clock from the shift register
// DONE  | result presented, waiting for out_ready
module ones_count_engine #(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  ones_count_engine_if.slave   bus,
  input  logic                 stat_clr,
  output logic [15:0]          words_done,
  output logic [15:0]          zero_words
);

  localparam int N_CHUNKS = DATA_W / CHUNK_W;
  localparam int CC_W     = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CC_W-1:0]   chunk_q, chunk_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              zero_q, zero_d;
  logic [15:0]       words_done_q, words_done_d;
  logic [15:0]       zero_words_q, zero_words_d;

  logic [CNT_W-1:0]  chunk_pop;
  logic [CNT_W-1:0]  acc_sum;
  logic              accept;
  logic              handshake;
  logic              last_chunk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = COUNT;
      COUNT:   if (last_chunk)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_count = count_q;
    bus.out_zero  = zero_q;
  end

  assign accept     = (state_q == IDLE) && bus.in_valid;
  assign handshake  = (state_q == DONE) && bus.out_ready;
  assign last_chunk = (chunk_q == '0);

  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      chunk_pop = chunk_pop + CNT_W'(shift_q[i]);
    end
  end

  assign acc_sum = acc_q + chunk_pop;

  always_comb begin
    shift_d = shift_q;
    acc_d   = acc_q;
    chunk_d = chunk_q;
    count_d = count_q;
    zero_d  = zero_q;
    if (accept) begin
      shift_d = bus.in_data;
      acc_d   = '0;
      chunk_d = CC_W'(N_CHUNKS - 1);
    end else if (state_q == COUNT) begin
      acc_d   = acc_sum;
      shift_d = shift_q >> CHUNK_W;
      if (last_chunk) begin
        count_d = acc_sum;
        zero_d  = (acc_sum == '0);
      end else begin
        chunk_d = chunk_q - CC_W'(1);
      end
    end
  end

  // Clear takes priority over a coincident handshake.
  always_comb begin
    words_done_d = words_done_q;
    zero_words_d = zero_words_q;
    if (stat_clr) begin
      words_done_d = '0;
      zero_words_d = '0;
    end else if (handshake) begin
      words_done_d = words_done_q + 16'd1;
      if (zero_q && (zero_words_q != 16'hFFFF)) begin
        zero_words_d = zero_words_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q      <= '0;
      acc_q        <= '0;
      chunk_q      <= '0;
      count_q      <= '0;
      zero_q       <= 1'b0;
      words_done_q <= '0;
      zero_words_q <= '0;
    end else begin
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      chunk_q      <= chunk_d;
      count_q      <= count_d;
      zero_q       <= zero_d;
      words_done_q <= words_done_d;
      zero_words_q <= zero_words_d;
    end
  end

  assign words_done = words_done_q;
  assign zero_words = zero_words_q;

endmodule
